// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Opcode values live here so decode-side code can agree on them.
package fetch_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT,
        S_ERROR
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory-side req/ack bus and decode-side valid/ready bus of the fetch sequencer.
// The sequencer uses the master view; memory and decode models use the slave view.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;

    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output branch_taken,
        output branch_target
    );

endinterface

// File: rtl/pc_core.sv
// Program-counter register: load has priority over increment,
// and increment wraps naturally at 2^ADDR_W.
module pc_core
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= '0;
        end else if (load) begin
            pc_reg <= next_pc;
        end else if (inc) begin
            pc_reg <= pc_reg + ONE;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: fetches one word at a time over req/ack, presents
// it to decode over valid/ready, then steps, jumps, branches or halts the PC.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt_req,
    fetch_sequencer_if.master   bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [CNT_W-1:0]    retired
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] instr_reg;
    logic              valid_reg;
    logic              req_reg;
    logic              busy_reg;
    logic              halted_reg;
    logic              error_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic              halt_latch_reg;

    logic [ADDR_W-1:0] pc_w;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_next;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] imm;
    logic              is_halt;
    logic              is_jmp;
    logic              handshake;
    logic              halt_pending;
    logic              tmo_expired;

    assign opcode       = instr_reg[DATA_W-1 -: 4];
    assign imm          = instr_reg[ADDR_W-1:0];
    assign is_halt      = (opcode == OP_HALT);
    assign is_jmp       = (opcode == OP_JMP);
    assign handshake    = (state_reg == S_ISSUE) && valid_reg && bus.instr_ready;
    assign halt_pending = halt_latch_reg | halt_req;
    assign tmo_expired  = (tmo_reg == TMO_LAST);

    // A jump outranks a decode redirect; HALT leaves the PC alone entirely.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        pc_next = is_jmp ? imm : bus.branch_target;
        if (handshake && !is_halt) begin
            if (is_jmp || bus.branch_taken) begin
                pc_load = 1'b1;
            end else begin
                pc_inc = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = halt_pending ? S_HALT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_next = S_ISSUE;
                end else if (tmo_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    if (is_halt || halt_pending) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_ERROR: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            instr_reg      <= '0;
            valid_reg      <= 1'b0;
            req_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            halted_reg     <= 1'b0;
            error_reg      <= 1'b0;
            retired_reg    <= '0;
            tmo_reg        <= '0;
            halt_latch_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            req_reg    <= (state_next == S_FETCH);
            valid_reg  <= (state_next == S_ISSUE);
            busy_reg   <= (state_next == S_FETCH) || (state_next == S_ISSUE);
            halted_reg <= (state_next == S_HALT);
            error_reg  <= (state_next == S_ERROR);

            if ((state_reg == S_FETCH) && bus.imem_ack) begin
                instr_reg <= bus.imem_data;
            end

            if ((state_reg == S_FETCH) && !bus.imem_ack && !tmo_expired) begin
                tmo_reg <= tmo_reg + TMO_ONE;
            end else begin
                tmo_reg <= '0;
            end

            if (state_next == S_HALT) begin
                halt_latch_reg <= 1'b0;
            end else if (halt_req && (state_reg != S_HALT)) begin
                halt_latch_reg <= 1'b1;
            end

            if (handshake && (retired_reg != {CNT_W{1'b1}})) begin
                retired_reg <= retired_reg + CNT_ONE;
            end
        end
    end

    pc_core #(
        .ADDR_W (ADDR_W)
    ) u_pc_core (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .next_pc (pc_next),
        .inc     (pc_inc),
        .pc      (pc_w)
    );

    assign bus.imem_req    = req_reg;
    assign bus.imem_addr   = pc_w;
    assign bus.instr       = instr_reg;
    assign bus.instr_valid = valid_reg;

    assign pc      = pc_w;
    assign busy    = busy_reg;
    assign halted  = halted_reg;
    assign error   = error_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs, expected issues queued
// by the stimulus and checked by an independent monitor on each handshake.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          halt_req;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          error;
    logic [CW-1:0] retired;

    fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fetch_sequencer #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_TIMEOUT (8),
        .CNT_W       (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt_req (halt_req),
        .bus      (bus),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .error    (error),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] ret;
    } exp_t;

    int            n_vec = 0;
    int            n_bad = 0;
    int            nret  = 0;
    exp_t          sb[$];
    logic [DW-1:0] mem[16];
    int            ack_lat = 1;
    bit            ack_en  = 1'b1;
    int            wcnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back('{addr: a, data: d, ret: CW'(nret)});
        nret++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int k;
        k = 0;
        while (!bus.instr_valid && k < limit) begin
            cycle();
            k++;
        end
        check("wait_valid", 32'(bus.instr_valid), 1);
    endtask

    task automatic wait_halted(input int limit);
        int k;
        k = 0;
        while (!halted && k < limit) begin
            cycle();
            k++;
        end
        check("wait_halted", 32'(halted), 1);
    endtask

    task automatic accept(input int stall, input logic [DW-1:0] stall_instr,
                          input logic br, input logic [AW-1:0] tgt);
        wait_valid(20);
        for (int s = 0; s < stall; s++) begin
            cycle();
            check("stall_instr", 32'(bus.instr), 32'(stall_instr));
            check("stall_valid", 32'(bus.instr_valid), 1);
        end
        bus.instr_ready   = 1'b1;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        cycle();
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
    endtask

    // Instruction memory model: acks ack_lat cycles after seeing a request.
    always @(negedge clk) begin
        if (bus.imem_req && ack_en && !bus.imem_ack) begin
            if (wcnt >= ack_lat) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = mem[bus.imem_addr];
                wcnt = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_issue: got addr %0h instr %0h, required none", pc, bus.instr);
            end else begin
                e = sb.pop_front();
                $display("txn addr=%0h instr=%02h retired=%0d", pc, bus.instr, retired);
                check("issue_addr", 32'(pc), 32'(e.addr));
                check("issue_instr", 32'(bus.instr), 32'(e.data));
                check("issue_retired", 32'(retired), 32'(e.ret));
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        halt_req = 1'b0;
        bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h01;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_error", 32'(error), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_req", 32'(bus.imem_req), 0);
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_instr", 32'(bus.instr), 0);
        rst = 1'b0;
        cycle();
        check("idle_busy", 32'(busy), 0);

        // Sequential run over all addresses plus wrap to 0, then halt_req stop.
        for (int i = 0; i < 17; i++) push(AW'(i % 16), 8'h01);
        bus.instr_ready = 1'b1;
        pulse_start();
        k = 0;
        while (sb.size() > 1 && k < 300) begin
            cycle();
            k++;
        end
        check("seq_sb_level", 32'(sb.size()), 1);
        check("seq_retired16", 32'(retired), 16);
        check("seq_wrap_pc", 32'(pc), 0);
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        wait_halted(50);
        bus.instr_ready = 1'b0;
        check("seq_halt_pc", 32'(pc), 1);
        check("seq_retired17", 32'(retired), 17);

        // Jump with decode backpressure.
        mem[2] = 8'hE9;
        mem[9] = 8'hF0;
        push(1, 8'h01);
        push(2, 8'hE9);
        push(9, 8'hF0);
        pulse_start();
        accept(0, 8'h00, 1'b0, '0);
        accept(3, 8'hE9, 1'b0, '0);
        check("jmp_pc", 32'(pc), 9);
        check("jmp_req", 32'(bus.imem_req), 1);
        check("jmp_addr", 32'(bus.imem_addr), 9);
        accept(0, 8'h00, 1'b0, '0);
        check("jmp_halted", 32'(halted), 1);
        check("jmp_halt_pc", 32'(pc), 9);

        // Branch redirect into a HALT opcode, then resume from the held pc.
        mem[9]  = 8'hE3;
        mem[3]  = 8'h01;
        mem[12] = 8'hF0;
        push(9, 8'hE3);
        push(3, 8'h01);
        push(12, 8'hF0);
        pulse_start();
        accept(0, 8'h00, 1'b0, '0);
        accept(0, 8'h00, 1'b1, 4'd12);
        check("br_pc", 32'(pc), 12);
        accept(0, 8'h00, 1'b0, '0);
        check("br_halted", 32'(halted), 1);
        check("br_halt_pc", 32'(pc), 12);
        mem[12] = 8'hE5;
        mem[5]  = 8'h01;
        push(12, 8'hE5);
        pulse_start();
        check("resume_req", 32'(bus.imem_req), 1);
        check("resume_addr", 32'(bus.imem_addr), 12);
        accept(0, 8'h00, 1'b0, '0);
        check("jmp5_pc", 32'(pc), 5);

        // halt_req pulsed during FETCH stops after that instruction.
        push(5, 8'h01);
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        accept(0, 8'h00, 1'b0, '0);
        check("hreq_halted", 32'(halted), 1);
        check("hreq_pc", 32'(pc), 6);

        // Memory never answers: ERROR after exactly 8 FETCH cycles, then retry.
        ack_en = 1'b0;
        pulse_start();
        repeat (7) cycle();
        check("tmo_not_yet", 32'(error), 0);
        check("tmo_req_held", 32'(bus.imem_req), 1);
        cycle();
        check("tmo_error", 32'(error), 1);
        check("tmo_req_drop", 32'(bus.imem_req), 0);
        check("tmo_pc", 32'(pc), 6);
        mem[6] = 8'hF0;
        push(6, 8'hF0);
        ack_en = 1'b1;
        pulse_start();
        check("retry_error", 32'(error), 0);
        check("retry_addr", 32'(bus.imem_addr), 6);
        accept(0, 8'h00, 1'b0, '0);
        check("retry_halted", 32'(halted), 1);

        // Reset while an instruction at pc=7 is waiting in ISSUE.
        mem[6] = 8'h01;
        push(6, 8'h01);
        pulse_start();
        accept(0, 8'h00, 1'b0, '0);
        wait_valid(20);
        check("pre_rst_pc", 32'(pc), 7);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.instr_valid), 0);
        check("arst_req", 32'(bus.imem_req), 0);
        check("arst_pc", 32'(pc), 0);
        check("arst_retired", 32'(retired), 0);
        check("arst_instr", 32'(bus.instr), 0);
        check("arst_busy", 32'(busy), 0);
        cycle();
        rst = 1'b0;
        nret = 0;
        cycle();
        check("post_rst_busy", 32'(busy), 0);

        // halt_req seen in IDLE turns the next start into HALT.
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        pulse_start();
        check("idle_halt", 32'(halted), 1);
        check("idle_halt_req", 32'(bus.imem_req), 0);
        push(0, 8'h01);
        pulse_start();
        check("idle_resume_addr", 32'(bus.imem_addr), 0);
        accept(0, 8'h00, 1'b0, '0);
        check("final_pc", 32'(pc), 1);
        check("final_retired", 32'(retired), 1);
        check("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns and sequences a 4-bit program counter.
- Issues read requests to instruction memory with a req/ack handshake and holds each fetched word.
- Presents the word downstream with a valid/ready handshake, then advances, branches, jumps or halts the PC.
- Sits between the PC and instruction memory on one side and the decode stage on the other.

Parameters:
ADDR_W, 4, PC / instruction-memory address width; PC wraps modulo 2^ADDR_W
DATA_W, 8, instruction width; opcode = top 4 bits, immediate = low ADDR_W bits
MEM_TIMEOUT, 8, max cycles in FETCH waiting for imem_ack before ERROR (>=1)
CNT_W, 8, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin/resume fetching (pulse or level)
halt_req  in  1  request stop at next instruction boundary (sticky once seen)
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  read address (= pc)
imem_ack  in  1  memory read done; imem_data valid same cycle
imem_data  in  DATA_W  fetched word
instr  out  DATA_W  held instruction to decode
instr_valid  out  1  instr is valid
instr_ready  in  1  decode accepts instr
branch_taken  in  1  decode redirect, sampled only on ISSUE handshake
branch_target  in  ADDR_W  redirect address
pc  out  ADDR_W  current program counter
busy  out  1  state is FETCH or ISSUE
halted  out  1  state is HALT
error  out  1  state is ERROR
retired  out  CNT_W  count of accepted instructions, saturating at all-ones

Behaviour:
- Reset (async): state IDLE; pc=0; instr=0; retired=0; halt latch=0; timeout count=0; all outputs low or zero.
- Opcodes:
  - 4'hF = HALT.
  - 4'hE = JMP; target = imm.
  - Others = normal instructions.
- IDLE: outputs idle. start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - Timeout count increments each FETCH cycle.
  - imem_ack=1: capture imem_data into instr, clear count, -> ISSUE.
  - Count reaches MEM_TIMEOUT without ack -> ERROR; ack on that same cycle wins.
  - Fetch latency: at least 1 cycle from FETCH entry to instr_valid.
- ISSUE:
  - instr_valid=1; instr held stable while instr_ready=0.
  - On the handshake (valid & ready), retired increments and pc is updated in this priority order:
    1. Opcode HALT: pc unchanged, -> HALT.
    2. Opcode JMP: pc <= imm.
    3. branch_taken=1: pc <= branch_target.
    4. Otherwise: pc <= pc+1, wrapping (2^ADDR_W-1) -> 0.
  - Next state after a non-HALT handshake: halt latch set (including halt_req asserted this cycle) -> HALT; else -> FETCH.
  - No handshake: stay in ISSUE.
- HALT:
  - halted=1; halt latch cleared on entry.
  - start=1 -> FETCH, resuming from the held pc.
  - halt_req while in HALT is ignored.
- ERROR: error=1, pc held. start=1 -> FETCH with the same pc (retry); timeout count cleared.
- halt_req latches in any state other than HALT. In IDLE, a latched halt moves to HALT on the next start instead of FETCH.
- Async rst mid-FETCH or mid-ISSUE drops imem_req and instr_valid immediately; no partial update survives.
- Only one outstanding memory request at a time; no prefetch.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, FETCH, ISSUE, HALT, ERROR);
  - opcode constants OP_HALT=4'hF and OP_JMP=4'hE;
  - ADDR_W/DATA_W defaults.
- One sub-module, pc_core:
  - ADDR_W-bit register with async reset to 0;
  - load/next_pc input and inc enable; wraps on increment.
- The sequencer FSM drives pc_core's load, next_pc and inc.

Test Plan:
1. Sequential run: reset, start, memory acks after 1 cycle with 8'h01 everywhere, ready=1 -> 16 fetches at addrs 0..15, then addr 0 again (wrap); retired=16 after sixteenth handshake.
2. Jump + backpressure: mem[2]=8'hE9; hold instr_ready=0 for 3 cycles in ISSUE -> instr stays 8'hE9, valid high; after accept pc=9, next imem_addr=9.
3. Branch + HALT: at pc=3 accept with branch_taken=1, target=12; mem[12]=8'hF0 -> pc=12, halted=1 with pc=12; start -> fetch resumes at addr 12.
4. halt_req + timeout: pulse halt_req during FETCH at pc=5 -> instruction 5 issues, pc=6, HALT. Then start with imem_ack never asserted -> error=1 after 8 FETCH cycles, pc=6; start plus ack -> recovers at addr 6.
5. Reset mid-op: assert rst during ISSUE at pc=7 -> instr_valid, imem_req, pc, retired all 0 immediately, state IDLE.
